// File: rtl/mmm_pkg.sv
// Shared types and helpers for the sequenced Montgomery multiplier.
package mmm_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} mmm_state_t;

    function automatic int cnt_width(int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mmm_step.sv
// One radix-2 Montgomery iteration: acc_o = (acc_i + a*B + q*M) >> 1.
module mmm_step #(
    parameter int unsigned Width = 8
) (
    input  logic [Width:0]   acc_i,
    input  logic             a_i,
    input  logic [Width-1:0] b_i,
    input  logic [Width-1:0] m_i,
    output logic [Width:0]   acc_o,
    output logic             q_o
);

    logic [Width-1:0] ab;
    logic [Width-1:0] qm;
    logic [Width+1:0] sum_ab;

    assign q_o = acc_i[0] ^ (a_i & b_i[0]);
    assign ab  = a_i ? b_i : '0;
    assign qm  = q_o ? m_i : '0;

    ripple_carry_adder #(
        .N(Width + 2)
    ) u_add_ab (
        .a_i  ({1'b0, acc_i}),
        .b_i  ({2'b00, ab}),
        .cin_i(1'b0),
        .sum_o(sum_ab)
    );

    // Shift before adding q*M: only the carry out of bit 0 survives the halving.
    ripple_carry_adder #(
        .N(Width + 1)
    ) u_add_qm (
        .a_i  (sum_ab[Width+1:1]),
        .b_i  ({2'b00, qm[Width-1:1]}),
        .cin_i(sum_ab[0] & qm[0]),
        .sum_o(acc_o)
    );

endmodule

// File: rtl/ripple_carry_adder.sv
// Plain N-bit ripple-carry adder; the carry out of the top bit is not produced.
module ripple_carry_adder #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o
);

    logic [N-1:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ carry[i];
        if (i < N - 1) begin : g_carry
            assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
    end

endmodule

// File: rtl/mmm_seq_engine.sv
// Self-sequenced bit-serial Montgomery multiplier: R = A*B*2^-WIDTH mod M.
module mmm_seq_engine
    import mmm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             clear,
    input  logic             start,
    input  logic             final_sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] M,
    output logic [WIDTH:0]   R,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(WIDTH - 1);

    mmm_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q, b_q, m_q;
    logic             fsub_q;
    logic [WIDTH:0]   acc_q, acc_step;
    logic [WIDTH:0]   r_q, r_final, m_ext;
    logic             err_q;
    logic             q_unused;

    mmm_step #(
        .Width(WIDTH)
    ) u_step (
        .acc_i(acc_q),
        .a_i  (a_q[cnt_q]),
        .b_i  (b_q),
        .m_i  (m_q),
        .acc_o(acc_step),
        .q_o  (q_unused)
    );

    assign m_ext   = {1'b0, m_q};
    assign r_final = (fsub_q && (acc_q >= m_ext)) ? (acc_q - m_ext) : acc_q;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= IDLE;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = M[0] ? RUN : DONE;
                RUN:     if (cnt_q == LastIdx) state_d = FINAL;
                FINAL:   state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == RUN) || (state_q == FINAL);
        done = (state_q == DONE);
    end

    // Datapath; an abort leaves R and err untouched.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            fsub_q <= 1'b0;
            acc_q  <= '0;
            r_q    <= '0;
            err_q  <= 1'b0;
        end else if (ena && !clear) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q    <= A;
                        b_q    <= B;
                        m_q    <= M;
                        fsub_q <= final_sub;
                        cnt_q  <= '0;
                        acc_q  <= '0;
                        if (M[0]) begin
                            err_q <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                            r_q   <= '0;
                        end
                    end
                end
                RUN: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                FINAL:   r_q <= r_final;
                default: ;
            endcase
        end
    end

    assign R   = r_q;
    assign err = err_q;

endmodule
